// File: rtl/imm_decode_pipe.sv
// RV32/RV64 immediate decoder with a two-entry (output + skid) valid/ready pipeline.
// Decode is combinational at the input; results are registered with 1-cycle latency.
// in_ready comes straight from the skid valid flop, so there is no ready-to-ready path.
module imm_decode_pipe #(
   parameter int unsigned XLEN       = 32,   // 32 or 64
   parameter bit          SHAMT_ZEXT = 1'b1  // reduce OP-IMM shift immediates to zero-extended shamt
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     iword,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] immediate,
   output logic [2:0]      fmt
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [2:0]      dec_fmt;
   logic [31:0]     dec_raw;
   logic [XLEN-1:0] dec_imm;

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_imm_q,   out_imm_d;
   logic [2:0]      out_fmt_q,   out_fmt_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
   logic [2:0]      skid_fmt_q,  skid_fmt_d;

   assign opcode = iword[6:0];
   assign funct3 = iword[14:12];

   // Opcode -> format, format -> 32-bit immediate, sign-extend, then the shamt override.
   always_comb begin
      dec_fmt = FMT_NONE;
      dec_raw = 32'd0;
      dec_imm = '0;

      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: dec_fmt = FMT_I;
         OP_IMM32:          dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
         OP_STORE:          dec_fmt = FMT_S;
         OP_BRANCH:         dec_fmt = FMT_B;
         OP_AUIPC, OP_LUI:  dec_fmt = FMT_U;
         OP_JAL:            dec_fmt = FMT_J;
         default:           dec_fmt = FMT_NONE;
      endcase

      case (dec_fmt)
         FMT_I: dec_raw = {{20{iword[31]}}, iword[31:20]};
         FMT_S: dec_raw = {{20{iword[31]}}, iword[31:25], iword[11:7]};
         FMT_B: dec_raw = {{19{iword[31]}}, iword[31], iword[7], iword[30:25], iword[11:8], 1'b0};
         FMT_U: dec_raw = {iword[31:12], 12'd0};
         FMT_J: dec_raw = {{11{iword[31]}}, iword[31], iword[19:12], iword[20], iword[30:21], 1'b0};
         default: dec_raw = 32'd0;
      endcase

      dec_imm = XLEN'($signed(dec_raw));

      // Shift-immediate: funct3 001 (sll) or 101 (srl/sra); the funct7 bits are dropped.
      if (SHAMT_ZEXT && (dec_fmt == FMT_I) && ((opcode == OP_IMM) || (opcode == OP_IMM32))
          && (funct3[1:0] == 2'b01)) begin
         if ((opcode == OP_IMM) && (XLEN == 64)) begin
            dec_imm = XLEN'(iword[25:20]);
         end else begin
            dec_imm = XLEN'(iword[24:20]);
         end
      end
   end

   // Next state of the OUT/SKID pair: drain SKID first, otherwise accept into OUT or SKID.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_fmt_d    = out_fmt_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_fmt_d   = skid_fmt_q;

      if (skid_valid_q) begin
         // in_ready is low here, so the only possible event is OUT being consumed.
         if (out_valid_q && out_ready) begin
            out_imm_d    = skid_imm_q;
            out_fmt_d    = skid_fmt_q;
            skid_valid_d = 1'b0;
         end
      end else if (in_valid) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm;
            out_fmt_d   = dec_fmt;
         end else begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; synchronous reset wins over any handshake on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_fmt_q    <= FMT_NONE;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_fmt_q   <= FMT_NONE;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_fmt_q    <= out_fmt_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_fmt_q   <= skid_fmt_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign immediate = out_imm_q;
   assign fmt       = out_fmt_q;

endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter SHAMT_ZEXT, default 1, meaning: 1 = OP-IMM shift immediates reduced to zero-extended shamt.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning iword is presented.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts iword this cycle.
REQ-007 SHALL have port iword, input, 32 bits, the RV32/RV64 instruction word.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning immediate and fmt hold a result.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-010 SHALL have port immediate, output, XLEN bits, the decoded immediate.
REQ-011 SHALL have port fmt, output, 3 bits, format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 unused.

Function
REQ-012 SHALL map opcode iword[6:0] to a format:
- I: 0000011, 0010011, 1100111, 1110011, plus 0011011 when XLEN=64.
- S: 0100011. B: 1100011. U: 0010111, 0110111. J: 1101111.
- Anything else, including 0011011 when XLEN=32: NONE.
REQ-013 SHALL build the immediate per format, then sign-extend from iword[31] to XLEN:
- I: iword[31:20].
- S: {iword[31:25], iword[11:7]}.
- B: {iword[31], iword[7], iword[30:25], iword[11:8], 0}.
- U: {iword[31:12], 12'b0}.
- J: {iword[31], iword[19:12], iword[20], iword[30:21], 0}.
REQ-014 SHALL output immediate = 0 for NONE.
REQ-015 SHALL apply the shamt rule when SHAMT_ZEXT=1, opcode 0010011 or 0011011, and funct3 iword[14:12] is 001 or 101:
- immediate = zero-extended iword[20+SW-1:20].
- SW = 6 for 0010011 with XLEN=64; SW = 5 otherwise.
- fmt stays I.
REQ-016 SHALL decode combinationally at the input and register the result, giving latency of exactly 1 cycle from acceptance to out_valid.
REQ-017 SHALL treat an input as accepted when in_valid and in_ready are both high at a clock edge, and an output as consumed when out_valid and out_ready are both high at a clock edge.
REQ-018 SHALL contain two entries, an output register (OUT) and a skid register (SKID), each with its own valid bit.
REQ-019 SHALL drive in_ready = NOT skid_valid, taken directly from a register with no combinational path from out_ready.
REQ-020 SHALL, on acceptance, write the decoded word to OUT if OUT is empty or is being consumed in the same cycle (and SKID is empty); otherwise it SHALL write it to SKID.
REQ-021 SHALL, when OUT is consumed while SKID is valid, move SKID to OUT in the same edge and clear skid_valid.
REQ-022 SHALL, in that same case, accept no new word that edge, because in_ready was low.
REQ-023 SHALL deliver words in strict acceptance order, with no loss and no duplication.
REQ-024 SHALL hold immediate and fmt stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain 1 word per cycle when out_ready is held high.
REQ-026 SHALL ignore iword contents when in_valid=0, so no state changes.

Reset
REQ-027 SHALL, in any cycle with rst=1 at the edge, set out_valid=0, skid_valid=0, immediate=0 and fmt=0 on that edge, discarding any in-flight words.
REQ-028 SHALL drive in_ready=1 from the first cycle after reset.
REQ-029 SHALL give rst priority over a simultaneous acceptance or consumption.

Verification
REQ-030 SHALL verify: XLEN=32, accept 0xFFF00093 (addi -1) with out_ready=1 -> next cycle out_valid=1, immediate 0xFFFFFFFF, fmt 1.
REQ-031 SHALL verify: accept 0xFE112E23 (sw -4) -> 0xFFFFFFFC, fmt 2; accept 0x00000033 -> 0x00000000, fmt 0.
REQ-032 SHALL verify: XLEN=64, accept 0x800000B7 (lui) -> 0xFFFFFFFF80000000, fmt 4; accept 0x03F09093 (slli 63) -> 0x3F; accept 0x43F0D093 (srai 63) -> 0x3F with SHAMT_ZEXT=1 and 0x43F with SHAMT_ZEXT=0.
REQ-033 SHALL verify backpressure: out_ready=0, present words A then B back-to-back -> both accepted, in_ready=0 after B; raise out_ready -> A then B delivered on consecutive cycles; in_ready returns to 1 on the edge B moves to OUT.
REQ-034 SHALL verify reset mid-operation: OUT and SKID full, assert rst one cycle -> out_valid=0, immediate=0, fmt=0, in_ready=1 next cycle; a new word is then accepted and emitted with 1-cycle latency.
REQ-035 SHALL verify random streams against a reference model, with random in_valid and out_ready -> order preserved, no drops, immediate stable under stall.
